// File: rtl/intersection_pkg.sv
// Shared types and constants for the intersection controller.
// Phase indices, FSM states and a one-hot helper.
package intersection_pkg;

  localparam int NUM_PHASES = 4;

  localparam logic [1:0] PH_NS_THRU = 2'd0;
  localparam logic [1:0] PH_EW_THRU = 2'd1;
  localparam logic [1:0] PH_NS_LEFT = 2'd2;
  localparam logic [1:0] PH_PED     = 2'd3;

  typedef enum logic [1:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALL_RED
  } state_t;

  function automatic logic [NUM_PHASES-1:0] ph_onehot(
    input logic [1:0] p
  );
    logic [NUM_PHASES-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req searching
// upward from start, wrapping modulo NUM_PHASES.
module rr_pick
  import intersection_pkg::*;
(
  input  logic [NUM_PHASES-1:0] req,
  input  logic [1:0]            start,
  output logic [NUM_PHASES-1:0] gnt,
  output logic [1:0]            idx,
  output logic                  valid
);

  logic [1:0] cand;

  // Scan farthest offset first so the nearest hit wins.
  always_comb begin
    gnt   = '0;
    idx   = start;
    valid = 1'b0;
    cand  = start;
    for (int k = NUM_PHASES - 1; k >= 0; k--) begin
      cand = start + 2'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
        gnt   = ph_onehot(cand);
      end
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// Traffic phase scheduler: GREEN/YELLOW/ALL_RED with call latching.
// Optional emergency preemption under EMERGENCY_PREEMPT_EN.
module phase_scheduler
  import intersection_pkg::*;
#(
  parameter int MIN_GREEN   = 8,
  parameter int MAX_GREEN   = 24,
  parameter int YELLOW_CYC  = 3,
  parameter int ALL_RED_CYC = 2,
  parameter int TIMER_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                  preempt,
  input  logic [1:0]            preempt_phase,
`endif
  input  logic [NUM_PHASES-1:0] req,
  input  logic [NUM_PHASES-1:0] presence,
  output logic [NUM_PHASES-1:0] green,
  output logic [NUM_PHASES-1:0] yellow,
  output logic                  all_red,
  output logic [1:0]            phase_id,
  output logic [NUM_PHASES-1:0] pending
);

  localparam logic [TIMER_W-1:0] MIN_T = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_T = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] Y_T   = TIMER_W'(YELLOW_CYC - 1);
  localparam logic [TIMER_W-1:0] R_T   = TIMER_W'(ALL_RED_CYC - 1);

  state_t                state;
  logic [TIMER_W-1:0]    timer;
  logic [NUM_PHASES-1:0] cur_oh;
  logic [NUM_PHASES-1:0] others;
  logic [NUM_PHASES-1:0] hold_mask;
  logic [NUM_PHASES-1:0] pend_in;
  logic [NUM_PHASES-1:0] next_oh;
  logic [1:0]            next_ph;
  logic                  normal_exit;
  logic                  green_exit;
  logic [NUM_PHASES-1:0] rr_gnt;
  logic [1:0]            rr_idx;
  logic                  rr_valid;

  rr_pick u_rr (
    .req   (pending),
    .start (phase_id + 2'd1),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  // Exit decision, next-phase choice and call latching.
  always_comb begin
    cur_oh      = ph_onehot(phase_id);
    others      = pending & ~cur_oh;
    normal_exit = (|others) && (timer >= MIN_T) &&
                  (!presence[phase_id] || timer >= MAX_T);
`ifdef EMERGENCY_PREEMPT_EN
    green_exit  = (state == ST_GREEN) &&
                  (preempt ? (preempt_phase != phase_id)
                           : normal_exit);
    next_ph     = preempt ? preempt_phase
                : (rr_valid ? rr_idx : phase_id);
    next_oh     = preempt ? ph_onehot(preempt_phase)
                : (rr_valid ? rr_gnt : cur_oh);
`else
    green_exit  = (state == ST_GREEN) && normal_exit;
    next_ph     = rr_valid ? rr_idx : phase_id;
    next_oh     = rr_valid ? rr_gnt : cur_oh;
`endif
    // A call for the serving phase is dropped only while it keeps green.
    hold_mask   = (state == ST_GREEN && !green_exit) ? cur_oh : '0;
    pend_in     = pending | (req & ~hold_mask);
  end

  // Phase FSM with registered lamp outputs and saturating timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_GREEN;
      timer    <= '0;
      phase_id <= PH_NS_THRU;
      green    <= ph_onehot(PH_NS_THRU);
      yellow   <= '0;
      all_red  <= 1'b0;
      pending  <= '0;
    end else begin
      pending <= pend_in;
      if (timer != '1) timer <= timer + TIMER_W'(1);
      unique case (state)
        ST_GREEN: begin
          if (green_exit) begin
            state  <= ST_YELLOW;
            timer  <= '0;
            green  <= '0;
            yellow <= cur_oh;
          end
        end
        ST_YELLOW: begin
          if (timer == Y_T) begin
            state   <= ST_ALL_RED;
            timer   <= '0;
            yellow  <= '0;
            all_red <= 1'b1;
          end
        end
        ST_ALL_RED: begin
          if (timer == R_T) begin
            state    <= ST_GREEN;
            timer    <= '0;
            all_red  <= 1'b0;
            phase_id <= next_ph;
            green    <= next_oh;
            pending  <= pend_in & ~next_oh;
          end
        end
        default: state <= ST_GREEN;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Table-driven bench for phase_scheduler with a per-cycle scoreboard.
// Each row drives inputs and queues expected lamp/pending values.
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] presence;
  logic       preempt;
  logic [1:0] preempt_phase;
  logic [3:0] green;
  logic [3:0] yellow;
  logic       all_red;
  logic [1:0] phase_id;
  logic [3:0] pending;

  phase_scheduler #(
    .MIN_GREEN  (8),
    .MAX_GREEN  (24),
    .YELLOW_CYC (3),
    .ALL_RED_CYC(2),
    .TIMER_W    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef EMERGENCY_PREEMPT_EN
    .preempt      (preempt),
    .preempt_phase(preempt_phase),
`endif
    .req          (req),
    .presence     (presence),
    .green        (green),
    .yellow       (yellow),
    .all_red      (all_red),
    .phase_id     (phase_id),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  rq;
    logic [3:0]  pr;
    bit          pe;
    logic [1:0]  pp;
    logic [14:0] exp;
    int          n;
    string       name;
  } vec_t;

  typedef struct {
    logic [14:0] v;
    string       name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  sb_t  mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [14:0] pk(
    logic [3:0] g, logic [3:0] y, logic ar,
    logic [1:0] ph, logic [3:0] pd
  );
    return {g, y, ar, ph, pd};
  endfunction

  function automatic logic [14:0] dut_now();
    return {green, yellow, all_red, phase_id, pending};
  endfunction

  task automatic chk(string nm, logic [14:0] act, logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got g=%b y=%b ar=%b ph=%0d pd=%b want g=%b y=%b ar=%b ph=%0d pd=%b",
               nm, $time, act[14:11], act[10:7], act[6], act[5:4], act[3:0],
               exp[14:11], exp[10:7], exp[6], exp[5:4], exp[3:0]);
    end
  endtask

  // Scoreboard consumer: one expected entry per cycle.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      chk(mon_e.name, dut_now(), mon_e.v);
    end
  end

  task automatic add(string nm, logic [3:0] rq, logic [3:0] pr,
                     bit pe, logic [1:0] pp, logic [3:0] g,
                     logic [3:0] y, logic ar, logic [1:0] ph,
                     logic [3:0] pd, int n);
    vec_t v;
    v.rst = 1'b0; v.rq = rq; v.pr = pr; v.pe = pe; v.pp = pp;
    v.exp = pk(g, y, ar, ph, pd); v.n = n; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic add_rst();
    vec_t v;
    v.rst = 1'b1; v.rq = '0; v.pr = '0; v.pe = 1'b0; v.pp = '0;
    v.exp = '0; v.n = 0; v.name = "rst";
    tbl.push_back(v);
  endtask

  task automatic G(string nm, logic [3:0] rq, logic [3:0] pr,
                   logic [3:0] g, logic [1:0] ph, logic [3:0] pd, int n);
    add(nm, rq, pr, 1'b0, 2'd0, g, 4'b0000, 1'b0, ph, pd, n);
  endtask

  task automatic Y(string nm, logic [3:0] pr, bit pe,
                   logic [1:0] ph, logic [3:0] pd);
    logic [3:0] yo;
    yo = 4'b0001 << ph;
    add(nm, 4'b0000, pr, pe, 2'd3, 4'b0000, yo, 1'b0, ph, pd, 3);
  endtask

  task automatic AR(string nm, logic [3:0] pr, bit pe,
                    logic [1:0] ph, logic [3:0] pd, int n);
    add(nm, 4'b0000, pr, pe, 2'd3, 4'b0000, 4'b0000, 1'b1, ph, pd, n);
  endtask

  task automatic do_reset();
    rst = 1'b0; req = '0; presence = '0;
    preempt = 1'b0; preempt_phase = '0;
    #1;
    chk("reset_vals", dut_now(), pk(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0000));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_row(vec_t v);
    sb_t e;
    if (v.rst) begin
      do_reset();
    end else begin
      req = v.rq; presence = v.pr;
      preempt = v.pe; preempt_phase = v.pp;
      e.v = v.exp; e.name = v.name;
      repeat (v.n) sbq.push_back(e);
      repeat (v.n) begin
        @(posedge clk);
        #1;
        req = '0;
      end
    end
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    rst = 1'b0; req = '0; presence = '0;
    preempt = 1'b0; preempt_phase = '0;
    @(posedge clk);
    #1;

    // idle rest on phase 0
    add_rst();
    G("idle", 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 50);

    // single call, no presence
    add_rst();
    G("s2_g0",   4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 2);
    G("s2_req",  4'b0010, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1);
    G("s2_g0p",  4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0010, 5);
    Y("s2_y",    4'b0000, 1'b0, 2'd0, 4'b0010);
    AR("s2_ar",  4'b0000, 1'b0, 2'd0, 4'b0010, 2);
    G("s2_g1",   4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b0000, 4);

    // presence extension up to the green cap
    add_rst();
    G("s3_g0",   4'b0000, 4'b0001, 4'b0001, 2'd0, 4'b0000, 2);
    G("s3_req",  4'b0100, 4'b0001, 4'b0001, 2'd0, 4'b0000, 1);
    G("s3_ext",  4'b0000, 4'b0001, 4'b0001, 2'd0, 4'b0100, 21);
    Y("s3_y",    4'b0001, 1'b0, 2'd0, 4'b0100);
    AR("s3_ar",  4'b0001, 1'b0, 2'd0, 4'b0100, 2);
    G("s3_g2",   4'b0000, 4'b0001, 4'b0100, 2'd2, 4'b0000, 4);

    // round-robin order 1, 3, 0
    add_rst();
    G("s4_g0",   4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 2);
    G("s4_req",  4'b1011, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1);
    G("s4_g0p",  4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b1010, 5);
    Y("s4_y0",   4'b0000, 1'b0, 2'd0, 4'b1010);
    AR("s4_ar0", 4'b0000, 1'b0, 2'd0, 4'b1010, 2);
    G("s4_g1",   4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b1000, 2);
    G("s4_rq0",  4'b0001, 4'b0000, 4'b0010, 2'd1, 4'b1000, 1);
    G("s4_g1p",  4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b1001, 5);
    Y("s4_y1",   4'b0000, 1'b0, 2'd1, 4'b1001);
    AR("s4_ar1", 4'b0000, 1'b0, 2'd1, 4'b1001, 2);
    G("s4_g3",   4'b0000, 4'b0000, 4'b1000, 2'd3, 4'b0001, 8);
    Y("s4_y3",   4'b0000, 1'b0, 2'd3, 4'b0001);
    AR("s4_ar3", 4'b0000, 1'b0, 2'd3, 4'b0001, 2);
    G("s4_g0b",  4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 4);

    // call on the green-to-yellow edge is latched
    add_rst();
    G("s6_g0",   4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 2);
    G("s6_req",  4'b0010, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1);
    G("s6_g0p",  4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0010, 4);
    G("s6_edge", 4'b0001, 4'b0000, 4'b0001, 2'd0, 4'b0010, 1);
    Y("s6_y0",   4'b0000, 1'b0, 2'd0, 4'b0011);
    AR("s6_ar0", 4'b0000, 1'b0, 2'd0, 4'b0011, 2);
    G("s6_g1",   4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b0001, 8);
    Y("s6_y1",   4'b0000, 1'b0, 2'd1, 4'b0001);
    AR("s6_ar1", 4'b0000, 1'b0, 2'd1, 4'b0001, 2);
    G("s6_g0b",  4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 4);
    run_tbl();

    // asynchronous reset on the second all-red cycle
    add_rst();
    G("s5_g0",   4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 2);
    G("s5_req",  4'b0010, 4'b0000, 4'b0001, 2'd0, 4'b0000, 1);
    G("s5_g0p",  4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0010, 5);
    Y("s5_y",    4'b0000, 1'b0, 2'd0, 4'b0010);
    AR("s5_ar",  4'b0000, 1'b0, 2'd0, 4'b0010, 1);
    run_tbl();
    chk("s5_ar2nd", dut_now(), pk(4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0010));
    #2;
    rst = 1'b0;
    #1;
    chk("s5_async", dut_now(), pk(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0000));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    G("s5_rest", 4'b0000, 4'b0000, 4'b0001, 2'd0, 4'b0000, 10);
    run_tbl();

`ifdef EMERGENCY_PREEMPT_EN
    // preempt to phase 3, hold past the cap, then release
    add_rst();
    add("p_g0",   4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0000, 1);
    add("p_go",   4'b0000, 4'b0000, 1'b1, 2'd3, 4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0000, 1);
    Y("p_y0",     4'b0000, 1'b1, 2'd0, 4'b0000);
    AR("p_ar0",   4'b0000, 1'b1, 2'd0, 4'b0000, 2);
    add("p_g3",   4'b0000, 4'b0000, 1'b1, 2'd3, 4'b1000, 4'b0000, 1'b0, 2'd3, 4'b0000, 1);
    add("p_req",  4'b0010, 4'b0000, 1'b1, 2'd3, 4'b1000, 4'b0000, 1'b0, 2'd3, 4'b0000, 1);
    add("p_hold", 4'b0000, 4'b0000, 1'b1, 2'd3, 4'b1000, 4'b0000, 1'b0, 2'd3, 4'b0010, 30);
    add("p_drop", 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b1000, 4'b0000, 1'b0, 2'd3, 4'b0010, 1);
    Y("p_y3",     4'b0000, 1'b0, 2'd3, 4'b0010);
    AR("p_ar3",   4'b0000, 1'b0, 2'd3, 4'b0010, 2);
    G("p_g1",     4'b0000, 4'b0000, 4'b0010, 2'd1, 4'b0000, 3);
    run_tbl();
`endif

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
